mem_resp_stage: RTL and testbench

Memory-access pipeline stage for the five-stage MIPS core. It replaces the fixed single-cycle data-SRAM read with a variable-latency request/response data bus (addr_ok/data_ok style), which the EX stage issues to. The stage holds the accepted EX instruction until its data response arrives and buffers early responses when WB stalls. It discards stale responses left by a pipeline flush, performs load alignment and merging (LW/LB/LBU/LH/LHU/LWL/LWR), and drives WB and the forwarding/interlock network.

---
 rtl/mem_resp_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_resp_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_resp_stage.sv
// MS stage on a variable-latency request/response data bus: holds one EX entry until its
// response, buffers early data while WB stalls, drops responses orphaned by a flush, aligns loads.
module mem_resp_stage #(
  parameter int DISCARD_W = 2,
  parameter int EXCODE_W  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                es_to_ms_valid,
  output logic                ms_allowin,
  input  logic                es_req,
  input  logic [31:0]         es_pc,
  input  logic [31:0]         es_alu_result,
  input  logic [31:0]         es_rt_value,
  input  logic [6:0]          es_ld_op,
  input  logic                es_res_from_mem,
  input  logic                es_gr_we,
  input  logic [4:0]          es_dest,
  input  logic                es_ex,
  input  logic [EXCODE_W-1:0] es_excode,
  input  logic                flush,
  input  logic                data_ok,
  input  logic [31:0]         rdata,
  input  logic                ws_allowin,
  output logic                ms_to_ws_valid,
  output logic [31:0]         ms_pc,
  output logic [31:0]         ms_result,
  output logic                ms_gr_we,
  output logic [4:0]          ms_dest,
  output logic                ms_ex,
  output logic [EXCODE_W-1:0] ms_excode,
  output logic                ms_fwd_valid,
  output logic [4:0]          ms_fwd_dest,
  output logic [31:0]         ms_fwd_data,
  output logic                ms_fwd_pending,
  output logic                ms_discard_full
);

  logic                 r_valid;
  logic                 r_wait;
  logic                 r_dbuf_valid;
  logic [31:0]          r_dbuf;
  logic [DISCARD_W-1:0] r_discard_cnt;
  logic [31:0]          r_pc;
  logic [31:0]          r_alu;
  logic [31:0]          r_rt;
  logic [6:0]           r_ld_op;
  logic                 r_res_from_mem;
  logic                 r_gr_we;
  logic [4:0]           r_dest;
  logic                 r_ex;
  logic [EXCODE_W-1:0]  r_excode;

  logic        w_cnt_zero;
  logic        w_cnt_full;
  logic        w_stale;
  logic        w_match;
  logic        w_orphan;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_capture;
  logic [31:0] w_ld_data;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lwl;
  logic [31:0] w_lwr;
  logic [31:0] w_load;
  logic [31:0] w_result;

  // Responses arrive in order, so anything counted as orphaned is older than the current entry.
  assign w_cnt_zero = (r_discard_cnt == '0);
  assign w_cnt_full = (r_discard_cnt == '1);
  assign w_stale    = data_ok && !w_cnt_zero;
  assign w_match    = data_ok && w_cnt_zero && r_valid && r_wait;
  assign w_orphan   = flush && r_valid && r_wait && !w_match;
  assign w_ready_go = !r_wait || (data_ok && w_cnt_zero) || r_ex;
  assign w_allowin  = !r_valid || (w_ready_go && ws_allowin);
  assign w_capture  = es_to_ms_valid && w_allowin && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_wait         <= 1'b0;
      r_dbuf_valid   <= 1'b0;
      r_dbuf         <= '0;
      r_discard_cnt  <= '0;
      r_pc           <= '0;
      r_alu          <= '0;
      r_rt           <= '0;
      r_ld_op        <= '0;
      r_res_from_mem <= 1'b0;
      r_gr_we        <= 1'b0;
      r_dest         <= '0;
      r_ex           <= 1'b0;
      r_excode       <= '0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_allowin) r_valid <= es_to_ms_valid;

      if (w_capture) begin
        r_pc           <= es_pc;
        r_alu          <= es_alu_result;
        r_rt           <= es_rt_value;
        r_ld_op        <= es_ld_op;
        r_res_from_mem <= es_res_from_mem;
        r_gr_we        <= es_gr_we;
        r_dest         <= es_dest;
        r_ex           <= es_ex;
        r_excode       <= es_excode;
        r_wait         <= es_req;
        r_dbuf_valid   <= 1'b0;
      end else if (w_match) begin
        r_wait       <= 1'b0;
        r_dbuf       <= rdata;
        r_dbuf_valid <= 1'b1;
      end else if (flush) begin
        r_wait <= 1'b0;
      end

      // A new orphan and a dropped stale response in the same cycle cancel out.
      if (w_orphan && !w_stale && !w_cnt_full)
        r_discard_cnt <= r_discard_cnt + DISCARD_W'(1);
      else if (w_stale && !w_orphan)
        r_discard_cnt <= r_discard_cnt - DISCARD_W'(1);
    end
  end

  assign w_ld_data = r_dbuf_valid ? r_dbuf : rdata;

  always_comb begin
    w_byte = w_ld_data[7:0];
    w_lwl  = w_ld_data;
    w_lwr  = w_ld_data;
    case (r_alu[1:0])
      2'd0: begin
        w_byte = w_ld_data[7:0];
        w_lwl  = {w_ld_data[7:0], r_rt[23:0]};
        w_lwr  = w_ld_data;
      end
      2'd1: begin
        w_byte = w_ld_data[15:8];
        w_lwl  = {w_ld_data[15:0], r_rt[15:0]};
        w_lwr  = {r_rt[31:24], w_ld_data[31:8]};
      end
      2'd2: begin
        w_byte = w_ld_data[23:16];
        w_lwl  = {w_ld_data[23:0], r_rt[7:0]};
        w_lwr  = {r_rt[31:16], w_ld_data[31:16]};
      end
      default: begin
        w_byte = w_ld_data[31:24];
        w_lwl  = w_ld_data;
        w_lwr  = {r_rt[31:8], w_ld_data[31:24]};
      end
    endcase
    w_half = r_alu[1] ? w_ld_data[31:16] : w_ld_data[15:0];

    w_load = w_ld_data;
    if (r_ld_op[6])      w_load = w_ld_data;
    else if (r_ld_op[5]) w_load = {{24{w_byte[7]}}, w_byte};
    else if (r_ld_op[4]) w_load = {24'h0, w_byte};
    else if (r_ld_op[3]) w_load = {{16{w_half[15]}}, w_half};
    else if (r_ld_op[2]) w_load = {16'h0, w_half};
    else if (r_ld_op[1]) w_load = w_lwl;
    else if (r_ld_op[0]) w_load = w_lwr;

    w_result = r_res_from_mem ? w_load : r_alu;
  end

  assign ms_allowin      = w_allowin;
  assign ms_to_ws_valid  = r_valid && w_ready_go && !flush;
  assign ms_pc           = r_pc;
  assign ms_result       = w_result;
  assign ms_gr_we        = r_gr_we;
  assign ms_dest         = r_dest;
  assign ms_ex           = r_ex;
  assign ms_excode       = r_excode;
  assign ms_fwd_valid    = r_valid && r_gr_we;
  assign ms_fwd_dest     = r_dest;
  assign ms_fwd_data     = w_result;
  assign ms_fwd_pending  = r_valid && r_gr_we && r_res_from_mem && !w_ready_go;
  assign ms_discard_full = w_cnt_full;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Scoreboard bench for mem_resp_stage: in-order bus model with orphan tracking,
// expected hand-offs queued at capture and checked by an independent monitor.
module tb_mem_resp_stage;
  localparam int DW = 2;
  localparam int EW = 5;
  localparam logic [6:0] LW  = 7'b1000000;
  localparam logic [6:0] LH  = 7'b0001000;
  localparam logic [6:0] LHU = 7'b0000100;

  logic          clk, reset;
  logic          es_to_ms_valid, ms_allowin, es_req;
  logic [31:0]   es_pc, es_alu_result, es_rt_value;
  logic [6:0]    es_ld_op;
  logic          es_res_from_mem, es_gr_we, es_ex;
  logic [4:0]    es_dest;
  logic [EW-1:0] es_excode;
  logic          flush, data_ok, ws_allowin;
  logic [31:0]   rdata;
  logic          ms_to_ws_valid, ms_gr_we, ms_ex;
  logic [31:0]   ms_pc, ms_result, ms_fwd_data;
  logic [4:0]    ms_dest, ms_fwd_dest;
  logic [EW-1:0] ms_excode;
  logic          ms_fwd_valid, ms_fwd_pending, ms_discard_full;

  mem_resp_stage #(.DISCARD_W(DW), .EXCODE_W(EW)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_req(es_req), .es_pc(es_pc), .es_alu_result(es_alu_result), .es_rt_value(es_rt_value),
    .es_ld_op(es_ld_op), .es_res_from_mem(es_res_from_mem), .es_gr_we(es_gr_we),
    .es_dest(es_dest), .es_ex(es_ex), .es_excode(es_excode), .flush(flush),
    .data_ok(data_ok), .rdata(rdata), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_result(ms_result),
    .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_ex(ms_ex), .ms_excode(ms_excode),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data),
    .ms_fwd_pending(ms_fwd_pending), .ms_discard_full(ms_discard_full)
  );

  typedef struct {
    logic [31:0] pc, result;
    logic gr_we, ex, rfm, req;
    logic [4:0] dest;
    logic [EW-1:0] excode;
    int id;
  } exp_t;
  typedef struct { int id; int due; logic [31:0] data; bit orphan; } bus_t;
  typedef struct {
    bit v, req, rfm, we, ex, fl, wsa, rst, chkrst;
    logic [31:0] pc, alu, rt;
    logic [6:0] op;
    logic [4:0] dest;
    logic [EW-1:0] exc;
  } stim_t;

  exp_t exp_q[$];
  bus_t bus_q[$];
  int cyc = 0, next_id = 0, deliv_cnt = 0, last_due = 0;
  bit cur_orphan = 0;
  int n_vec = 0, n_err = 0;
  int force_lat = 0;
  bit force_dat_en = 0;
  logic [31:0] force_dat = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference load alignment written as byte arithmetic on 64-bit values.
  function automatic logic [31:0] ref_load(input logic [6:0] op, input logic [1:0] k2,
                                           input logic [31:0] d, input logic [31:0] rt);
    logic [63:0] dd, rr, m;
    logic [7:0] b;
    logic [15:0] h;
    int k, sh;
    k  = int'(k2);
    dd = {32'h0, d};
    rr = {32'h0, rt};
    b  = 8'(d >> (8 * k));
    h  = 16'(d >> (16 * (k / 2)));
    if (op[6]) return d;
    if (op[5]) return 32'($signed(b));
    if (op[4]) return 32'(b);
    if (op[3]) return 32'($signed(h));
    if (op[2]) return 32'(h);
    if (op[1]) begin
      sh = 8 * (3 - k);
      m  = (64'h1 << sh) - 64'h1;
      return 32'((dd << sh) | (rr & m));
    end
    sh = 8 * (4 - k);
    m  = (64'h1 << sh) - 64'h1;
    return 32'((dd >> (8 * k)) | (rr & ~m));
  endfunction

  function automatic bit entry_ready(input exp_t e);
    return !e.req || e.ex || (e.id < deliv_cnt);
  endfunction

  function automatic int orphan_cnt();
    int n = 0;
    foreach (bus_q[j]) n += int'(bus_q[j].orphan);
    return n;
  endfunction

  function automatic stim_t idle(input bit wsa = 1'b1);
    stim_t s;
    s = '{default: '0};
    s.wsa = wsa;
    return s;
  endfunction

  function automatic stim_t ld(input logic [6:0] op, input logic [31:0] addr);
    stim_t s;
    s = idle();
    s.v = 1; s.req = 1; s.rfm = 1; s.we = 1;
    s.op = op; s.alu = addr; s.rt = 32'h11223344;
    s.pc = 32'h0040_0000 + addr; s.dest = 5'd9;
    return s;
  endfunction

  task automatic check_reset();
    chk1("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    chk1("rst_allowin", ms_allowin, 1'b1);
    chk32("rst_pc", ms_pc, 32'h0);
    chk32("rst_result", ms_result, 32'h0);
    chk1("rst_gr_we", ms_gr_we, 1'b0);
    chk32("rst_dest", 32'(ms_dest), 32'h0);
    chk1("rst_ex", ms_ex, 1'b0);
    chk32("rst_excode", 32'(ms_excode), 32'h0);
    chk1("rst_fwd_valid", ms_fwd_valid, 1'b0);
    chk32("rst_fwd_dest", 32'(ms_fwd_dest), 32'h0);
    chk32("rst_fwd_data", ms_fwd_data, 32'h0);
    chk1("rst_fwd_pending", ms_fwd_pending, 1'b0);
    chk1("rst_discard_full", ms_discard_full, 1'b0);
  endtask

  // One clock: bus drives at negedge+1, monitor checks at +3, capture decision at +4.
  task automatic do_cycle(input stim_t s);
    bit rdy, alw, cap;
    exp_t e;
    bus_t b;
    @(negedge clk); #1;
    cyc++;
    reset = s.rst;
    if (!s.rst && bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      data_ok = 1'b1; rdata = bus_q[0].data; cur_orphan = bus_q[0].orphan;
      void'(bus_q.pop_front());
      deliv_cnt++;
    end else begin
      data_ok = 1'b0; rdata = $urandom; cur_orphan = 0;
    end
    es_to_ms_valid = s.v; es_req = s.req; es_pc = s.pc; es_alu_result = s.alu;
    es_rt_value = s.rt; es_ld_op = s.op; es_res_from_mem = s.rfm; es_gr_we = s.we;
    es_dest = s.dest; es_ex = s.ex; es_excode = s.exc; flush = s.fl; ws_allowin = s.wsa;
    #3;
    if (s.chkrst) check_reset();
    rdy = exp_q.size() > 0 && entry_ready(exp_q[0]);
    alw = exp_q.size() == 0 || (rdy && s.wsa);
    cap = s.v && alw && !s.fl && !s.rst;
    if (!s.rst && s.fl && exp_q.size() > 0 && exp_q[0].req && exp_q[0].id >= deliv_cnt)
      foreach (bus_q[j]) if (bus_q[j].id == exp_q[0].id) bus_q[j].orphan = 1;
    @(posedge clk); #1;
    if (s.rst) begin
      exp_q.delete(); bus_q.delete();
      deliv_cnt = next_id; last_due = cyc;
    end else begin
      if (s.fl) exp_q.delete();
      if (cap) begin
        b.data = force_dat_en ? force_dat : $urandom;
        e.pc = s.pc; e.gr_we = s.we; e.ex = s.ex; e.rfm = s.rfm; e.req = s.req;
        e.dest = s.dest; e.excode = s.exc; e.id = -1;
        e.result = s.rfm ? ref_load(s.op, s.alu[1:0], b.data, s.rt) : s.alu;
        if (s.req) begin
          b.id = next_id++;
          b.due = cyc + ((force_lat > 0) ? force_lat : int'($urandom_range(1, 5)));
          if (b.due <= last_due) b.due = last_due + 1;
          last_due = b.due;
          b.orphan = 0;
          bus_q.push_back(b);
          e.id = b.id;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: compares the DUT's outputs to the model and retires entries on hand-off.
  bit m_has, m_rdy, m_ev;
  always begin
    @(negedge clk); #3;
    if (!reset) begin
      m_has = exp_q.size() > 0;
      m_rdy = m_has && entry_ready(exp_q[0]);
      m_ev  = m_rdy && !flush;
      chk1("to_ws_valid", ms_to_ws_valid, m_ev);
      chk1("allowin", ms_allowin, !m_has || (m_rdy && ws_allowin));
      chk1("fwd_valid", ms_fwd_valid, m_has && exp_q[0].gr_we);
      chk1("fwd_pending", ms_fwd_pending, m_has && exp_q[0].gr_we && exp_q[0].rfm && !m_rdy);
      chk1("discard_full", ms_discard_full, (orphan_cnt() + int'(cur_orphan)) == 3);
      if (m_has) begin
        chk32("dest", 32'(ms_dest), 32'(exp_q[0].dest));
        chk32("fwd_dest", 32'(ms_fwd_dest), 32'(exp_q[0].dest));
      end
      if (m_ev) begin
        chk32("pc", ms_pc, exp_q[0].pc);
        chk32("result", ms_result, exp_q[0].result);
        chk32("fwd_data", ms_fwd_data, exp_q[0].result);
        chk1("gr_we", ms_gr_we, exp_q[0].gr_we);
        chk1("ex", ms_ex, exp_q[0].ex);
        chk32("excode", 32'(ms_excode), 32'(exp_q[0].excode));
        if (ws_allowin) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    stim_t s;
    int kind, t;
    reset = 1'b1; es_to_ms_valid = 0; es_req = 0; es_pc = '0; es_alu_result = '0;
    es_rt_value = '0; es_ld_op = '0; es_res_from_mem = 0; es_gr_we = 0; es_dest = '0;
    es_ex = 0; es_excode = '0; flush = 0; data_ok = 0; rdata = '0; ws_allowin = 0;

    s = idle(); s.rst = 1;
    repeat (3) do_cycle(s);
    s = idle(); s.chkrst = 1;
    do_cycle(s);

    // LW with a 3-cycle response.
    force_dat_en = 1; force_dat = 32'h8899AABB; force_lat = 3;
    do_cycle(ld(LW, 32'h1000_0004));
    repeat (5) do_cycle(idle());

    // Alignment sweep, issued back to back with single-cycle responses.
    force_lat = 1;
    for (int o = 0; o < 6; o++)
      for (int k = 0; k < 4; k++) begin
        logic [6:0] op;
        op = 7'(1 << o);
        if ((op == LH || op == LHU) && (k % 2) == 1) continue;
        do_cycle(ld(op, 32'h1000_0000 + 32'(k)));
      end
    repeat (3) do_cycle(idle());

    // Response arrives while WB stalls; buffered value must hold.
    force_lat = 2; force_dat = 32'hCAFE_F00D;
    do_cycle(ld(7'b0100000, 32'h2000_0003));
    repeat (4) do_cycle(idle(1'b0));
    repeat (2) do_cycle(idle());

    // Flush during a pending load, then a new load behind the stale response.
    force_lat = 4; force_dat = 32'h0000_DEAD;
    do_cycle(ld(LW, 32'h3000_0000));
    do_cycle(idle());
    s = idle(); s.fl = 1; do_cycle(s);
    force_lat = 1; force_dat = 32'h0000_1234;
    do_cycle(ld(LW, 32'h3000_0010));
    repeat (8) do_cycle(idle());

    // Flush of a waiting entry in the same cycle a stale response is dropped.
    force_lat = 6; force_dat = 32'h0BAD_0001;
    do_cycle(ld(LW, 32'h4000_0000));
    s = idle(); s.fl = 1; do_cycle(s);
    force_lat = 1; force_dat = 32'h0BAD_0002;
    do_cycle(ld(LW, 32'h4000_0004));
    for (t = 0; t < 20 && !(bus_q.size() > 0 && bus_q[0].due == cyc + 1); t++) do_cycle(idle());
    s = idle(); s.fl = 1; do_cycle(s);
    force_dat = 32'h5555_AAAA;
    do_cycle(ld(LW, 32'h4000_0008));
    repeat (6) do_cycle(idle());

    // Three orphaned requests saturate the discard counter.
    force_lat = 15;
    for (int i = 0; i < 3; i++) begin
      force_dat = 32'hF000_0000 + 32'(i);
      do_cycle(ld(LW, 32'h5000_0000 + 32'(4 * i)));
      s = idle(); s.fl = 1; do_cycle(s);
    end
    repeat (20) do_cycle(idle());

    // Exception entry passes straight through.
    s = idle(); s.v = 1; s.ex = 1; s.we = 1; s.exc = 5'h0C; s.pc = 32'h0040_1000;
    s.alu = 32'h1357_9BDF; s.dest = 5'd3;
    do_cycle(s);
    do_cycle(idle());

    // Reset while a load waits.
    force_lat = 10;
    do_cycle(ld(LW, 32'h6000_0000));
    repeat (2) do_cycle(idle());
    s = idle(); s.rst = 1; do_cycle(s);
    s = idle(); s.chkrst = 1; do_cycle(s);

    // Randomized traffic.
    force_lat = 0; force_dat_en = 0;
    for (int i = 0; i < 1500; i++) begin
      s = idle();
      s.v = ($urandom_range(0, 3) != 0);
      s.pc = $urandom; s.alu = $urandom; s.rt = $urandom;
      s.dest = 5'($urandom); s.exc = EW'($urandom);
      s.wsa = ($urandom_range(0, 3) != 0);
      s.fl = ($urandom_range(0, 19) == 0);
      kind = $urandom_range(0, 9);
      if (orphan_cnt() >= 3 && kind < 7) kind = 8;
      if (kind < 6) begin
        s.req = 1; s.rfm = 1; s.we = 1;
        s.op = 7'(1 << $urandom_range(0, 6));
        if (s.op == LW) s.alu[1:0] = 2'b00;
        if (s.op == LH || s.op == LHU) s.alu[0] = 1'b0;
      end else if (kind == 6) begin
        s.req = 1;
      end else if (kind == 9) begin
        s.ex = 1; s.we = 1'($urandom);
      end else begin
        s.we = 1'($urandom);
      end
      do_cycle(s);
    end

    for (t = 0; t < 50 && (exp_q.size() > 0 || bus_q.size() > 0); t++) do_cycle(idle());
    chk32("drain_empty", 32'(exp_q.size() + bus_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
